regfile_wb_scheduler: RTL and testbench

Write-port scheduler and hazard scoreboard for the 16 x 8-bit CPU register file.
- Arbitrates two writeback requesters onto the single register-file write port: ALU result and memory load.
- Keeps a 16-entry busy scoreboard.
- Stalls instruction issue while any source or destination register has a write outstanding.
- Sits between issue/decode, the execution units and the register file's rd / data_in / enable_write inputs.

---
 rtl/regfile_wb_scheduler.sv | 113 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: ALU/load writeback arbitration plus busy scoreboard.
// Build option WB_FIXED_PRIO_EN: ALU always wins over load, no round-robin pointer.
module regfile_wb_scheduler #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs,
  input  logic [AW-1:0]   iss_rt,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_wr,
  output logic            iss_stall,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [DW-1:0]   mem_data,
  output logic            mem_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [DW-1:0]   rf_data,
  output logic [NREG-1:0] busy_vec,
  output logic            wb_err
);

  logic [NREG-1:0] r_busy;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_rd;
  logic [DW-1:0]   r_rf_data;
  logic            r_wb_err;

  logic            w_alu_xfer;
  logic            w_mem_xfer;
  logic            w_xfer;
  logic            w_issue;
  logic [AW-1:0]   w_g_rd;
  logic [DW-1:0]   w_g_data;
  logic [NREG-1:0] w_busy_nxt;

  // RAW on either source, WAW on the destination
  assign iss_stall = iss_valid &
                     (r_busy[iss_rs] | r_busy[iss_rt] | (iss_wr & r_busy[iss_rd]));
  assign w_issue   = iss_valid & ~iss_stall & iss_wr;

`ifdef WB_FIXED_PRIO_EN
  assign alu_ready = alu_valid;
  assign mem_ready = mem_valid & ~alu_valid;
`else
  // state    | meaning
  // PRIO_ALU | ALU wins a tie (reset value, or load granted last)
  // PRIO_MEM | load wins a tie (ALU granted last)
  typedef enum logic {PRIO_ALU, PRIO_MEM} prio_e;
  prio_e r_prio;
  prio_e w_prio_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_prio <= PRIO_ALU;
    else     r_prio <= w_prio_nxt;
  end

  always_comb begin
    w_prio_nxt = r_prio;
    if (w_alu_xfer)      w_prio_nxt = PRIO_MEM;
    else if (w_mem_xfer) w_prio_nxt = PRIO_ALU;
  end

  assign alu_ready = alu_valid & (~mem_valid | (r_prio == PRIO_ALU));
  assign mem_ready = mem_valid & (~alu_valid | (r_prio == PRIO_MEM));
`endif

  assign w_alu_xfer = alu_ready;
  assign w_mem_xfer = mem_ready;
  assign w_xfer     = w_alu_xfer | w_mem_xfer;
  assign w_g_rd     = w_alu_xfer ? alu_rd   : mem_rd;
  assign w_g_data   = w_alu_xfer ? alu_data : mem_data;

  // A new claim on a register overrides the retiring write's clear
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_we) w_busy_nxt[r_rf_rd] = 1'b0;
    if (w_issue) w_busy_nxt[iss_rd]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_rf_we   <= 1'b0;
      r_rf_rd   <= '0;
      r_rf_data <= '0;
      r_wb_err  <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_rf_we <= w_xfer;
      if (w_xfer) begin
        r_rf_rd   <= w_g_rd;
        r_rf_data <= w_g_data;
      end
      if (w_xfer & ~r_busy[w_g_rd]) r_wb_err <= 1'b1;
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_rd    = r_rf_rd;
  assign rf_data  = r_rf_data;
  assign busy_vec = r_busy;
  assign wb_err   = r_wb_err;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed plan steps plus a randomized run against a behavioural model.
module tb_regfile_wb_scheduler;
  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid, iss_wr, iss_stall;
  logic [AW-1:0]   iss_rs, iss_rt, iss_rd;
  logic            alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0]   alu_rd, mem_rd;
  logic [DW-1:0]   alu_data, mem_data;
  logic            rf_we, wb_err;
  logic [AW-1:0]   rf_rd;
  logic [DW-1:0]   rf_data;
  logic [NREG-1:0] busy_vec;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model
  bit [NREG-1:0] m_busy;
  bit            m_we;
  bit [AW-1:0]   m_rd;
  bit [DW-1:0]   m_data;
  bit            m_err;
  bit            m_last_alu;
  bit            e_stall, e_ar, e_mr;
  bit            d_ar, d_mr;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd),
    .iss_wr(iss_wr), .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
    .busy_vec(busy_vec), .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    e_stall = iss_valid && (m_busy[iss_rs] || m_busy[iss_rt] || (iss_wr && m_busy[iss_rd]));
    if (alu_valid && mem_valid) begin
`ifdef WB_FIXED_PRIO_EN
      e_ar = 1'b1;
      e_mr = 1'b0;
`else
      e_ar = !m_last_alu;
      e_mr = m_last_alu;
`endif
    end else begin
      e_ar = alu_valid;
      e_mr = mem_valid;
    end
  endtask

  task automatic model_edge();
    bit [NREG-1:0] nb;
    bit            x;
    bit [AW-1:0]   grd;
    bit [DW-1:0]   gdat;
    if (rst) begin
      m_busy = '0; m_we = 0; m_rd = '0; m_data = '0; m_err = 0; m_last_alu = 0;
    end else begin
      nb   = m_busy;
      x    = e_ar || e_mr;
      grd  = e_ar ? alu_rd : mem_rd;
      gdat = e_ar ? alu_data : mem_data;
      if (x && !m_busy[grd]) m_err = 1;
      if (m_we) nb[m_rd] = 0;
      if (iss_valid && !e_stall && iss_wr) nb[iss_rd] = 1;
      m_busy = nb;
      m_we   = x;
      if (x) begin
        m_rd = grd;
        m_data = gdat;
        m_last_alu = e_ar;
      end
    end
  endtask

  // Inputs are already driven; check combinational outputs, clock once, check registered ones.
  task automatic cyc();
    #1;
    model_comb();
    d_ar = alu_ready;
    d_mr = mem_ready;
    chk("iss_stall", iss_stall, e_stall);
    chk("alu_ready", alu_ready, e_ar);
    chk("mem_ready", mem_ready, e_mr);
    @(posedge clk);
    model_edge();
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_data", rf_data, m_data);
    chk("busy_vec", busy_vec, m_busy);
    chk("wb_err", wb_err, m_err);
  endtask

  task automatic idle();
    iss_valid = 0; iss_wr = 0; iss_rs = '0; iss_rt = '0; iss_rd = '0;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic issue_wr(input int r);
    iss_valid = 1; iss_wr = 1; iss_rs = '0; iss_rt = '0; iss_rd = AW'(r);
    cyc();
  endtask

  initial begin
    int aq[$];
    int mq[$];
    bit [3:0] ga, gm;
    bit av, mv;
    int pk;

    idle();
    rst = 1;
    cyc();
    cyc();
    rst = 0;

    // 1: reset state
    iss_valid = 1; iss_rs = 4'd2; iss_rt = 4'd3; iss_rd = 4'd4; iss_wr = 0;
    cyc();
    chk("t1_stall", iss_stall, 0);
    chk("t1_rf_we", rf_we, 0);
    chk("t1_busy", busy_vec, 16'h0000);
    chk("t1_err", wb_err, 0);

    // 2: RAW stall, writeback, same-cycle-write still stalls
    issue_wr(4);
    chk("t2_busy_set", busy_vec, 16'h0010);
    iss_rs = 4'd4; iss_rt = 4'd3; iss_wr = 0;
    cyc();
    chk("t2_stall", iss_stall, 1);
    alu_valid = 1; alu_rd = 4'd4; alu_data = 8'd30;
    cyc();
    chk("t2_alu_ready", d_ar, 1);
    chk("t2_we", rf_we, 1);
    chk("t2_rd", rf_rd, 4);
    chk("t2_data", rf_data, 30);
    chk("t2_stall_during_write", iss_stall, 1);
    alu_valid = 0;
    cyc();
    chk("t2_busy_clr", busy_vec, 16'h0000);
    chk("t2_stall_drop", iss_stall, 0);

    // 3: simultaneous requests from fresh pointer
    idle(); rst = 1; cyc(); rst = 0;
    issue_wr(5);
    issue_wr(6);
    iss_valid = 0; iss_wr = 0;
    alu_valid = 1; alu_rd = 4'd5; alu_data = 8'h11;
    mem_valid = 1; mem_rd = 4'd6; mem_data = 8'h22;
    cyc();
    chk("t3_first_alu", {d_ar, d_mr}, 2'b10);
    chk("t3_data0", rf_data, 8'h11);
    alu_valid = 0;
    cyc();
    chk("t3_second_mem", d_mr, 1);
    chk("t3_we1", rf_we, 1);
    chk("t3_data1", rf_data, 8'h22);
    mem_valid = 0;
    cyc();
    chk("t3_busy", busy_vec, 16'h0000);

    // 4: streaming contention
    for (int r = 8; r < 16; r++) issue_wr(r);
    iss_valid = 0; iss_wr = 0;
    aq = '{8, 9, 10, 11};
    mq = '{12, 13, 14, 15};
    ga = '0; gm = '0;
    for (int c = 0; c < 20 && (aq.size() > 0 || mq.size() > 0); c++) begin
      alu_valid = aq.size() > 0;
      if (alu_valid) begin alu_rd = AW'(aq[0]); alu_data = DW'(8'h40 + aq[0]); end
      mem_valid = mq.size() > 0;
      if (mem_valid) begin mem_rd = AW'(mq[0]); mem_data = DW'(8'h80 + mq[0]); end
      cyc();
      if (c < 4) begin ga[c] = d_ar; gm[c] = d_mr; end
      if (e_ar) void'(aq.pop_front());
      if (e_mr) void'(mq.pop_front());
    end
`ifdef WB_FIXED_PRIO_EN
    chk("t4_alu_grants", ga, 4'b1111);
    chk("t4_mem_grants", gm, 4'b0000);
`else
    chk("t4_alu_grants", ga, 4'b0101);
    chk("t4_mem_grants", gm, 4'b1010);
`endif
    idle();
    cyc();
    cyc();
    chk("t4_busy", busy_vec, 16'h0000);
    chk("t4_err", wb_err, 0);

    // 5: write to a register that is not busy
    mem_valid = 1; mem_rd = 4'd9; mem_data = 8'h99;
    cyc();
    chk("t5_rd", rf_rd, 9);
    chk("t5_we", rf_we, 1);
    chk("t5_err", wb_err, 1);
    idle();
    for (int i = 0; i < 3; i++) cyc();
    chk("t5_err_sticky", wb_err, 1);

    // 6: reset with busy bits and a write in flight
    issue_wr(4);
    issue_wr(5);
    chk("t6_busy", busy_vec, 16'h0030);
    iss_valid = 0; iss_wr = 0;
    alu_valid = 1; alu_rd = 4'd4; alu_data = 8'h55;
    cyc();
    chk("t6_inflight", rf_we, 1);
    alu_valid = 0; rst = 1;
    cyc();
    chk("t6_busy0", busy_vec, 16'h0000);
    chk("t6_we0", rf_we, 0);
    chk("t6_err0", wb_err, 0);
    rst = 0;

    // randomized run
    av = 0; mv = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      iss_valid = 1'($urandom_range(0, 1));
      iss_wr    = 1'($urandom_range(0, 1));
      iss_rs    = AW'($urandom_range(0, 15));
      iss_rt    = AW'($urandom_range(0, 15));
      iss_rd    = AW'($urandom_range(0, 15));
      if (!av && $urandom_range(0, 2) != 0) begin
        pk = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) if (m_busy[(pk + k) % 16] && $urandom_range(0, 4) != 0) begin
          pk = (pk + k) % 16;
          break;
        end
        av = 1; alu_rd = AW'(pk); alu_data = DW'($urandom_range(0, 255));
      end
      if (!mv && $urandom_range(0, 2) != 0) begin
        pk = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) if (m_busy[(pk + k) % 16] && $urandom_range(0, 4) != 0) begin
          pk = (pk + k) % 16;
          break;
        end
        mv = 1; mem_rd = AW'(pk); mem_data = DW'($urandom_range(0, 255));
      end
      alu_valid = av;
      mem_valid = mv;
      cyc();
      if (e_ar || rst) av = 0;
      if (e_mr || rst) mv = 0;
    end
    rst = 0;
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
